// File: rtl/xadc_multi_channel_scanner_if.sv
// DRP bus between the XADC wizard and the channel scanner.
// The scanner uses the master modport and the XADC side uses the slave modport.
interface xadc_multi_channel_scanner_if;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_daddr, drp_den, drp_dwe, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_daddr, drp_den, drp_dwe, drp_di,
        output drp_do, drp_drdy
    );
endinterface

// File: rtl/xadc_multi_channel_scanner.sv
// Round-robin XADC DRP read sequencer: it emits tagged 12-bit samples and keeps the latest sample per channel.
// Defining XADC_AVG_EN makes each channel strobe the average of every 4 captured samples.
module xadc_multi_channel_scanner #(
    parameter int unsigned         NUM_CH       = 2,
    parameter logic [7*NUM_CH-1:0] CH_ADDR_LIST = {7'h1B, 7'h13},
    parameter int unsigned         TIMEOUT_CYC  = 255,
    parameter int unsigned         SCAN_GAP_CYC = 0
) (
    input  logic                                clk_35mhz,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [2:0]                          sel_ch,
    xadc_multi_channel_scanner_if.master        drp,
    output logic                                smp_valid,
    output logic [2:0]                          smp_ch,
    output logic [11:0]                         smp_data,
    output logic                                timeout_err,
    output logic [15:0]                         disp_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    localparam logic [2:0]  LAST_CH  = 3'(NUM_CH - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] GAP_LAST = 16'(SCAN_GAP_CYC - 1);

    state_t      state, state_nxt;
    logic [2:0]  ch, ch_nxt;
    logic [15:0] timer, gap_cnt;
    logic [6:0]  daddr, addr_nxt;
    logic        capture, timed_out;
    logic [11:0] cap_val;
    logic [11:0] sample [NUM_CH];
    logic [15:0] disp_nxt;
    logic        unused_do_lsbs;

    assign cap_val        = drp.drp_do[15:4];
    assign unused_do_lsbs = ^drp.drp_do[3:0];

    always_comb begin
        drp.drp_daddr = daddr;
        drp.drp_den   = (state == ISSUE);
        drp.drp_dwe   = 1'b0;
        drp.drp_di    = '0;
    end

    // The timeout fires on the TIMEOUT_CYC-th WAIT cycle; drdy on that same cycle wins.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        capture   = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE:  if (enable) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                capture   = drp.drp_drdy;
                timed_out = !drp.drp_drdy && (timer == TO_LAST);
                if (capture || timed_out) begin
                    ch_nxt = (ch == LAST_CH) ? '0 : ch + 3'd1;
                    if (SCAN_GAP_CYC != 0) state_nxt = GAP;
                    else                   state_nxt = enable ? ISSUE : IDLE;
                end
            end
            GAP:   if (gap_cnt == GAP_LAST) state_nxt = enable ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_nxt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (ch_nxt == 3'(i)) addr_nxt = CH_ADDR_LIST[7*i +: 7];
    end

    always_comb begin
        disp_nxt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (sel_ch == 3'(i)) disp_nxt = {{1'b0, sel_ch} + 4'd1, sample[i]};
    end

`ifdef XADC_AVG_EN
    logic [13:0] acc [NUM_CH];
    logic [1:0]  cnt [NUM_CH];
    logic [13:0] acc_cur, avg_sum;
    logic [1:0]  cnt_cur;

    always_comb begin
        acc_cur = '0;
        cnt_cur = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            if (ch == 3'(i)) begin
                acc_cur = acc[i];
                cnt_cur = cnt[i];
            end
        avg_sum = acc_cur + {2'b00, cap_val};
    end
`endif

    always_ff @(posedge clk_35mhz) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_35mhz) begin
        if (reset) begin
            ch          <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            daddr       <= '0;
            smp_valid   <= 1'b0;
            smp_ch      <= '0;
            smp_data    <= '0;
            timeout_err <= 1'b0;
            disp_data   <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                sample[i] <= '0;
`ifdef XADC_AVG_EN
                acc[i]    <= '0;
                cnt[i]    <= '0;
`endif
            end
        end else begin
            ch        <= ch_nxt;
            smp_valid <= 1'b0;
            timer     <= (state == WAIT) ? timer + 16'd1 : '0;
            gap_cnt   <= (state == GAP) ? gap_cnt + 16'd1 : '0;
            disp_data <= disp_nxt;
            if (state_nxt == ISSUE) daddr <= addr_nxt;
            if (timed_out) timeout_err <= 1'b1;
            if (capture) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (ch == 3'(i)) begin
`ifdef XADC_AVG_EN
                        if (cnt_cur == 2'd3) begin
                            sample[i] <= avg_sum[13:2];
                            acc[i]    <= '0;
                            cnt[i]    <= '0;
                        end else begin
                            acc[i]    <= avg_sum;
                            cnt[i]    <= cnt_cur + 2'd1;
                        end
`else
                        sample[i] <= cap_val;
`endif
                    end
                end
`ifdef XADC_AVG_EN
                if (cnt_cur == 2'd3) begin
                    smp_valid <= 1'b1;
                    smp_ch    <= ch;
                    smp_data  <= avg_sum[13:2];
                end
`else
                smp_valid <= 1'b1;
                smp_ch    <= ch;
                smp_data  <= cap_val;
`endif
            end
        end
    end
endmodule

// File: tb/tb_xadc_multi_channel_scanner.sv
// Directed bench for xadc_multi_channel_scanner: two instances (no gap / 4-cycle gap) each driven by a DRP responder model.
// Expected values are hand-computed from the cycle on which den is observed.
module tb_xadc_multi_channel_scanner;
    logic clk_35mhz = 1'b0;
    always #5 clk_35mhz = ~clk_35mhz;

    int unsigned total = 0;
    int unsigned bad   = 0;

    xadc_multi_channel_scanner_if if_a ();
    xadc_multi_channel_scanner_if if_b ();

    logic        reset_a, reset_b, en_a, en_b;
    logic [2:0]  sel_a, sel_b;
    logic        valid_a, valid_b, terr_a, terr_b;
    logic [2:0]  ch_a, ch_b;
    logic [11:0] data_a, data_b;
    logic [15:0] disp_a, disp_b;

    xadc_multi_channel_scanner #(
        .NUM_CH(2), .CH_ADDR_LIST({7'h1B, 7'h13}), .TIMEOUT_CYC(10), .SCAN_GAP_CYC(0)
    ) dut_a (
        .clk_35mhz(clk_35mhz), .reset(reset_a), .enable(en_a), .sel_ch(sel_a), .drp(if_a),
        .smp_valid(valid_a), .smp_ch(ch_a), .smp_data(data_a), .timeout_err(terr_a), .disp_data(disp_a)
    );

    xadc_multi_channel_scanner #(
        .NUM_CH(2), .CH_ADDR_LIST({7'h1B, 7'h13}), .TIMEOUT_CYC(255), .SCAN_GAP_CYC(4)
    ) dut_b (
        .clk_35mhz(clk_35mhz), .reset(reset_b), .enable(en_b), .sel_ch(sel_b), .drp(if_b),
        .smp_valid(valid_b), .smp_ch(ch_b), .smp_data(data_b), .timeout_err(terr_b), .disp_data(disp_b)
    );

    // DRP responders act on the falling edge: drdy arrives 'delay' cycles after the den cycle.
    int unsigned cd_a = 0, delay_a = 3, cd_b = 0, delay_b = 3;
    bit          noresp_a = 1'b0;
    logic [15:0] d0_a = '0, d1_a = '0, d_b = '0;
    logic [6:0]  lat_a = '0;

    always @(negedge clk_35mhz) begin
        if_a.drp_drdy = 1'b0;
        if (if_a.drp_den) begin
            cd_a  = noresp_a ? 0 : delay_a;
            lat_a = if_a.drp_daddr;
        end else if (cd_a != 0) begin
            cd_a--;
            if (cd_a == 0) begin
                if_a.drp_drdy = 1'b1;
                if_a.drp_do   = (lat_a == 7'h1B) ? d1_a : d0_a;
            end
        end
    end

    always @(negedge clk_35mhz) begin
        if_b.drp_drdy = 1'b0;
        if (if_b.drp_den) cd_b = delay_b;
        else if (cd_b != 0) begin
            cd_b--;
            if (cd_b == 0) begin
                if_b.drp_drdy = 1'b1;
                if_b.drp_do   = d_b;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk_35mhz);
        #1;
    endtask

    task automatic wait_den(input bit use_b, input int unsigned max);
        int unsigned k = 0;
        while (!(use_b ? if_b.drp_den : if_a.drp_den) && k < max) begin
            step(1);
            k++;
        end
        if (!(use_b ? if_b.drp_den : if_a.drp_den)) check("den_wait_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;
        logic [11:0] avg_in [4];
        avg_in = '{12'd100, 12'd200, 12'd300, 12'd400};
        reset_a = 1'b1; reset_b = 1'b1; en_a = 1'b0; en_b = 1'b0; sel_a = '0; sel_b = '0;
        if_a.drp_drdy = 1'b0; if_a.drp_do = '0; if_b.drp_drdy = 1'b0; if_b.drp_do = '0;
        step(3);
        check("rst_den", if_a.drp_den, 0);
        check("rst_daddr", if_a.drp_daddr, 0);
        check("rst_valid", valid_a, 0);
        check("rst_terr", terr_a, 0);
        check("rst_disp", disp_a, 0);
        check("rst_dwe_di", {if_a.drp_dwe, if_a.drp_di}, 0);

        reset_a = 1'b0; reset_b = 1'b0; en_a = 1'b1;
        d0_a = 16'hABC0; d1_a = 16'hABC0;
`ifdef XADC_AVG_EN
        d1_a = 16'h0400;
        for (int k = 0; k < 8; k++) begin
            wait_den(1'b0, 8);
            if (k % 2 == 0) d0_a = {avg_in[k/2], 4'h0};
            step(4);
            check("avg_valid", valid_a, (k >= 6));
            if (k == 6) check("avg_ch0", {ch_a, data_a}, {3'd0, 12'd250});
            if (k == 7) check("avg_ch1", {ch_a, data_a}, {3'd1, 12'h040});
        end
        en_a = 1'b0;
        step(2);
        check("avg_disp", disp_a, 16'h10FA);
`else
        // Back-to-back reads alternating channels, drdy 3 cycles after den.
        for (int k = 0; k < 4; k++) begin
            wait_den(1'b0, 8);
            check("t1_addr", if_a.drp_daddr, (k % 2 == 0) ? 7'h13 : 7'h1B);
            step(3);
            check("t1_early", valid_a, 0);
            step(1);
            check("t1_valid", valid_a, 1);
            check("t1_ch", ch_a, k % 2);
            check("t1_data", data_a, 12'hABC);
            check("t1_b2b_den", if_a.drp_den, 1);
        end

        // Enable dropped during WAIT: current read still strobes, then idle.
        step(1); en_a = 1'b0;
        step(3);
        check("t3_valid", valid_a, 1);
        check("t3_ch", ch_a, 0);
        check("t3_den", if_a.drp_den, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            cnt += int'(if_a.drp_den) + int'(valid_a);
        end
        check("t3_quiet", cnt, 0);

        // Display mux: resumes on ch1, then out-of-range select.
        d0_a = 16'h4560; d1_a = 16'h1230; sel_a = 3'd1; en_a = 1'b1;
        wait_den(1'b0, 4);
        check("t4_addr", if_a.drp_daddr, 7'h1B);
        en_a = 1'b0;
        step(4);
        check("t4_smp", {valid_a, ch_a, data_a}, {1'b1, 3'd1, 12'h123});
        check("t4_disp_old", disp_a, 16'h2ABC);
        step(1);
        check("t4_disp_new", disp_a, 16'h2123);
        sel_a = 3'd5; step(1);
        check("t4_disp_oor", disp_a, 16'h0000);
        sel_a = 3'd0; step(1);
        check("t4_disp_ch0", disp_a, 16'h1ABC);

        // Timeout: no drdy, TIMEOUT_CYC=10.
        noresp_a = 1'b1; en_a = 1'b1;
        wait_den(1'b0, 4);
        check("t2_addr", if_a.drp_daddr, 7'h13);
        cnt = 0;
        for (int i = 1; i <= 11; i++) begin
            step(1);
            cnt += int'(valid_a);
            if (i == 10) check("t2_terr_early", terr_a, 0);
        end
        check("t2_terr", terr_a, 1);
        check("t2_no_strobe", cnt, 0);
        check("t2_next_den", {if_a.drp_den, if_a.drp_daddr}, {1'b1, 7'h1B});
        check("t2_sample_kept", disp_a, 16'h1ABC);

        // drdy on the final WAIT cycle counts as success.
        noresp_a = 1'b0; delay_a = 10; d1_a = 16'hDEF0; en_a = 1'b0;
        step(10);
        check("edge_early", valid_a, 0);
        step(1);
        check("edge_smp", {valid_a, ch_a, data_a}, {1'b1, 3'd1, 12'hDEF});
        check("edge_idle", if_a.drp_den, 0);

        // Reset during WAIT with drdy the following cycle.
        delay_a = 2; en_a = 1'b1;
        wait_den(1'b0, 4);
        step(1);
        reset_a = 1'b1; en_a = 1'b0;
        step(1);
        check("t7_outs", {if_a.drp_den, if_a.drp_daddr, valid_a, terr_a, disp_a}, 0);
        reset_a = 1'b0;
        step(1);
        check("t7_no_strobe", valid_a, 0);
        step(2);
        check("t7_disp", {valid_a, if_a.drp_den, disp_a}, {2'b00, 16'h1000});

        // Scan gap of 4 cycles on the second instance.
        d_b = 16'h7770; en_b = 1'b1;
        wait_den(1'b1, 4);
        check("t5_addr0", if_b.drp_daddr, 7'h13);
        step(4);
        check("t5_smp", {valid_b, data_b}, {1'b1, 12'h777});
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cnt += int'(if_b.drp_den);
            step(1);
        end
        check("t5_gap_quiet", cnt, 0);
        check("t5_next_den", {if_b.drp_den, if_b.drp_daddr}, {1'b1, 7'h1B});
        check("t5_terr", terr_b, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
